// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 10-key keypad front end.
// The optional auto-repeat feature is enabled by defining KEYPAD_AUTOREPEAT_EN.
package keypad_pkg;

    localparam int unsigned KP_KEY_COUNT = 10;

    typedef enum logic [1:0] {
        KP_IDLE,
        KP_PRESSED,
        KP_MULTI
    } kp_state_t;

    localparam logic [KP_KEY_COUNT-1:0] KP_ONE = KP_KEY_COUNT'(1);

    // True when exactly one bit of the key vector is set.
    function automatic logic kp_is_onehot(input logic [KP_KEY_COUNT-1:0] v);
        return (v != '0) && ((v & (v - KP_ONE)) == '0);
    endfunction

endpackage

// File: rtl/keypad_debounce_10_filter.sv
// Two-flop synchroniser plus stability filter: a synchronised value is accepted
// into o_stable only after CYCLES consecutive unchanged samples.
module debounce_filter #(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned CYCLES = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_stable
);

    localparam int unsigned   CW      = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] stable;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_d;

    // Count consecutive unchanged samples, saturating at CYCLES.
    always_comb begin
        cnt_d = cnt;
        if (sync2 != prev) begin
            cnt_d = '0;
        end else if (cnt != CNT_MAX) begin
            cnt_d = cnt + CNT_ONE;
        end
    end

    // Synchroniser, history register, counter and accepted value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1  <= '0;
            sync2  <= '0;
            prev   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            sync1 <= i_raw;
            sync2 <= sync1;
            prev  <= sync2;
            cnt   <= cnt_d;
            if (cnt_d == CNT_MAX) begin
                stable <= sync2;
            end
        end
    end

    assign o_stable = stable;

endmodule

// File: rtl/keypad_debounce_10.sv
// Debounced 10-key keypad front end: filters raw key lines and presents either
// nothing or a single key to the downstream encoder; multi-key patterns are
// flagged on o_multi instead. Define KEYPAD_AUTOREPEAT_EN for auto-repeat strobes.
module keypad_debounce_10
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 256,
    parameter int unsigned REPEAT_PERIOD   = 64
`endif
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [KP_KEY_COUNT-1:0] i_keys,
    output logic [KP_KEY_COUNT-1:0] o_keys,
    output logic                    o_strobe,
    output logic                    o_multi
);

    logic [KP_KEY_COUNT-1:0] stable;
    kp_state_t               state;
    kp_state_t               state_d;
    logic [KP_KEY_COUNT-1:0] keys_q;
    logic [KP_KEY_COUNT-1:0] keys_d;
    logic                    strobe_q;
    logic                    strobe_d;
    logic                    multi_q;
    logic                    multi_d;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned   RW         = $clog2(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_FIRE   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam logic [RW-1:0] RPT_ONE    = RW'(1);

    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_d;
`endif

    debounce_filter #(
        .WIDTH  (KP_KEY_COUNT),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_filter (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_raw    (i_keys),
        .o_stable (stable)
    );

    // Next state and next registered outputs from the accepted key value.
    always_comb begin
        state_d  = state;
        keys_d   = keys_q;
        strobe_d = 1'b0;
        multi_d  = multi_q;
`ifdef KEYPAD_AUTOREPEAT_EN
        rcnt_d   = rcnt;
`endif
        case (state)
            KP_IDLE: begin
                keys_d  = '0;
                multi_d = 1'b0;
                if (kp_is_onehot(stable)) begin
                    state_d  = KP_PRESSED;
                    keys_d   = stable;
                    strobe_d = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rcnt_d   = '0;
`endif
                end else if (stable != '0) begin
                    state_d = KP_MULTI;
                    multi_d = 1'b1;
                end
            end
            KP_PRESSED: begin
                if (stable == '0) begin
                    state_d = KP_IDLE;
                    keys_d  = '0;
                end else if (stable != keys_q) begin
                    state_d = KP_MULTI;
                    keys_d  = '0;
                    multi_d = 1'b1;
                end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                    // First repeat after REPEAT_DELAY, then every REPEAT_PERIOD.
                    if (rcnt == RPT_FIRE) begin
                        strobe_d = 1'b1;
                        rcnt_d   = RPT_RELOAD;
                    end else begin
                        rcnt_d = rcnt + RPT_ONE;
                    end
`endif
                end
            end
            KP_MULTI: begin
                // No rollover: everything must be released before a new press.
                if (stable == '0) begin
                    state_d = KP_IDLE;
                    multi_d = 1'b0;
                end
            end
            default: begin
                state_d = KP_IDLE;
                keys_d  = '0;
                multi_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= KP_IDLE;
            keys_q   <= '0;
            strobe_q <= 1'b0;
            multi_q  <= 1'b0;
        end else begin
            state    <= state_d;
            keys_q   <= keys_d;
            strobe_q <= strobe_d;
            multi_q  <= multi_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    // Repeat counter, only meaningful while a single key is held.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rcnt <= '0;
        end else begin
            rcnt <= rcnt_d;
        end
    end
`endif

    assign o_keys   = keys_q;
    assign o_strobe = strobe_q;
    assign o_multi  = multi_q;

endmodule
